// File: rtl/clock_display_pkg.sv
// Shared types, segment constants and the BCD-to-segment decode for the clock display driver.
package clock_display_pkg;

    localparam int BCD_W = 4;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_SHIFT  = 3'd2;
    localparam state_t ST_STORE  = 3'd3;
    localparam state_t ST_COMMIT = 3'd4;

    typedef enum logic [1:0] {
        FLD_SEC = 2'd0,
        FLD_MIN = 2'd1,
        FLD_HR  = 2'd2
    } field_e;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (digit <= 4'd9) seg = SEG_DIGIT[digit];
        return seg;
    endfunction

endpackage

// File: rtl/bcd_dabble7.sv
// Sequential double-dabble converter: 7-bit binary to two BCD digits, one bit per shift cycle.
module bcd_dabble7
    import clock_display_pkg::*;
(
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [6:0] value_i,
    output logic [7:0] bcd_o
);

    logic [6:0] bin_q, bin_d;
    logic [7:0] bcd_q, bcd_d;
    logic [7:0] adj;

    // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        adj   = bcd_q;
        if (load_i) begin
            bin_d = value_i;
            bcd_d = '0;
        end else if (shift_i) begin
            if (adj[BCD_W-1:0] >= 4'd5)       adj[BCD_W-1:0]       = adj[BCD_W-1:0] + 4'd3;
            if (adj[2*BCD_W-1:BCD_W] >= 4'd5) adj[2*BCD_W-1:BCD_W] = adj[2*BCD_W-1:BCD_W] + 4'd3;
            bcd_d = {adj[6:0], bin_q[6]};
            bin_d = {bin_q[5:0], 1'b0};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/clock_display_driver.sv
// Six-digit HH:MM:SS 7-segment driver with a shared sequential BCD converter, alarm blink and buzzer.
module clock_display_driver
    import clock_display_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2,
    parameter int BUZZ_HZ  = 2000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [15:0] hours_i,
    input  logic [15:0] minutes_i,
    input  logic [15:0] seconds_i,
    input  logic        alarm_i,
    output logic [6:0]  hex0_o,
    output logic [6:0]  hex1_o,
    output logic [6:0]  hex2_o,
    output logic [6:0]  hex3_o,
    output logic [6:0]  hex4_o,
    output logic [6:0]  hex5_o,
    output logic        buzzer_o,
    output logic        busy_o
);

    localparam int HB   = CLK_HZ / (2 * BLINK_HZ);
    localparam int HZ   = CLK_HZ / (2 * BUZZ_HZ);
    localparam int HB_W = (HB > 1) ? $clog2(HB) : 1;
    localparam int HZ_W = (HZ > 1) ? $clog2(HZ) : 1;

    state_t           state_q, state_d;
    field_e           field_q, field_d;
    logic [2:0]       shift_cnt_q, shift_cnt_d;
    logic [15:0]      snap_h_q, snap_h_d, snap_m_q, snap_m_d, snap_s_q, snap_s_d;
    logic             snap_valid_q, snap_valid_d;
    logic [5:0][6:0]  shadow_q, shadow_d;
    logic [5:0][6:0]  disp_q, disp_d;
    logic [HB_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic             phase_on_q, phase_on_d;
    logic [HZ_W-1:0]  tone_cnt_q, tone_cnt_d;
    logic             tone_q, tone_d;
    logic             buzzer_q, buzzer_d;

    logic             conv_load, conv_shift;
    logic [15:0]      sel_field;
    logic [7:0]       conv_bcd;

    always_comb begin
        case (field_q)
            FLD_SEC: sel_field = snap_s_q;
            FLD_MIN: sel_field = snap_m_q;
            default: sel_field = snap_h_q;
        endcase
    end

    bcd_dabble7 u_conv (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .load_i      (conv_load),
        .shift_i     (conv_shift),
        .value_i     (sel_field[6:0]),
        .bcd_o       (conv_bcd)
    );

    always_comb begin
        state_d      = state_q;
        field_d      = field_q;
        shift_cnt_d  = shift_cnt_q;
        snap_h_d     = snap_h_q;
        snap_m_d     = snap_m_q;
        snap_s_d     = snap_s_q;
        snap_valid_d = snap_valid_q;
        shadow_d     = shadow_q;
        disp_d       = disp_q;
        conv_load    = 1'b0;
        conv_shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!snap_valid_q || hours_i != snap_h_q || minutes_i != snap_m_q
                    || seconds_i != snap_s_q) begin
                    snap_h_d     = hours_i;
                    snap_m_d     = minutes_i;
                    snap_s_d     = seconds_i;
                    snap_valid_d = 1'b1;
                    field_d      = FLD_SEC;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                conv_load   = 1'b1;
                shift_cnt_d = '0;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                conv_shift = 1'b1;
                if (shift_cnt_q == 3'd6) state_d = ST_STORE;
                else                     shift_cnt_d = shift_cnt_q + 3'd1;
            end
            ST_STORE: begin
                // Out-of-range fields show dashes; the converter still ran its full 7 shifts.
                if (sel_field > 16'd99) begin
                    shadow_d[{field_q, 1'b1}] = SEG_DASH;
                    shadow_d[{field_q, 1'b0}] = SEG_DASH;
                end else begin
                    shadow_d[{field_q, 1'b1}] = seg_decode(conv_bcd[2*BCD_W-1:BCD_W]);
                    shadow_d[{field_q, 1'b0}] = seg_decode(conv_bcd[BCD_W-1:0]);
                end
                case (field_q)
                    FLD_SEC: begin field_d = FLD_MIN; state_d = ST_LOAD;   end
                    FLD_MIN: begin field_d = FLD_HR;  state_d = ST_LOAD;   end
                    default: begin                    state_d = ST_COMMIT; end
                endcase
            end
            ST_COMMIT: begin
                disp_d  = shadow_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        blink_cnt_d = '0;
        phase_on_d  = 1'b1;
        tone_cnt_d  = '0;
        tone_d      = 1'b0;
        if (alarm_i) begin
            phase_on_d = phase_on_q;
            tone_d     = tone_q;
            if (blink_cnt_q == HB_W'(HB - 1)) phase_on_d = ~phase_on_q;
            else                              blink_cnt_d = blink_cnt_q + HB_W'(1);
            if (tone_cnt_q == HZ_W'(HZ - 1))  tone_d = ~tone_q;
            else                              tone_cnt_d = tone_cnt_q + HZ_W'(1);
        end
        buzzer_d = tone_q & alarm_i & phase_on_q;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= ST_IDLE;
            field_q      <= FLD_SEC;
            shift_cnt_q  <= '0;
            snap_h_q     <= '0;
            snap_m_q     <= '0;
            snap_s_q     <= '0;
            snap_valid_q <= 1'b0;
            // NOTE: the digit registers are reset because they drive the outputs directly; reset blanks the display.
            shadow_q     <= {6{SEG_BLANK}};
            disp_q       <= {6{SEG_BLANK}};
            blink_cnt_q  <= '0;
            phase_on_q   <= 1'b1;
            tone_cnt_q   <= '0;
            tone_q       <= 1'b0;
            buzzer_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            field_q      <= field_d;
            shift_cnt_q  <= shift_cnt_d;
            snap_h_q     <= snap_h_d;
            snap_m_q     <= snap_m_d;
            snap_s_q     <= snap_s_d;
            snap_valid_q <= snap_valid_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_on_q   <= phase_on_d;
            tone_cnt_q   <= tone_cnt_d;
            tone_q       <= tone_d;
            buzzer_q     <= buzzer_d;
        end
    end

    assign hex0_o   = phase_on_q ? disp_q[0] : SEG_BLANK;
    assign hex1_o   = phase_on_q ? disp_q[1] : SEG_BLANK;
    assign hex2_o   = phase_on_q ? disp_q[2] : SEG_BLANK;
    assign hex3_o   = phase_on_q ? disp_q[3] : SEG_BLANK;
    assign hex4_o   = phase_on_q ? disp_q[4] : SEG_BLANK;
    assign hex5_o   = phase_on_q ? disp_q[5] : SEG_BLANK;
    assign buzzer_o = buzzer_q;
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed bench: expected displays are queued when inputs are driven and checked at each commit.
module tb_clock_display_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hours, minutes, seconds;
    logic        alarm;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        buzzer, busy;
    logic [41:0] hex_bus;

    int          checks = 0;
    int          errors = 0;
    logic [41:0] sb_q[$];
    logic [41:0] last_disp;

    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    clock_display_driver #(.CLK_HZ(16), .BLINK_HZ(2), .BUZZ_HZ(4)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .hours_i     (hours),
        .minutes_i   (minutes),
        .seconds_i   (seconds),
        .alarm_i     (alarm),
        .hex0_o      (hex0),
        .hex1_o      (hex1),
        .hex2_o      (hex2),
        .hex3_o      (hex3),
        .hex4_o      (hex4),
        .hex5_o      (hex5),
        .buzzer_o    (buzzer),
        .busy_o      (busy)
    );

    assign hex_bus = {hex5, hex4, hex3, hex2, hex1, hex0};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] pair(input int v);
        if (v > 99) return {7'h3F, 7'h3F};
        return {seg_tab[v / 10], seg_tab[v % 10]};
    endfunction

    function automatic logic [41:0] exp_disp(input int h, input int m, input int s);
        return {pair(h), pair(m), pair(s)};
    endfunction

    task automatic drive(input int h, input int m, input int s);
        hours   = 16'(h);
        minutes = 16'(m);
        seconds = 16'(s);
        sb_q.push_back(exp_disp(h, m, s));
    endtask

    // Waits for a conversion to start and finish, checking length, tearing and the committed value.
    task automatic wait_conv(input string tag, input bit check_len);
        int          len;
        int          wait_n;
        bit          tear;
        logic [41:0] exp;
        wait_n = 0;
        tear   = 1'b0;
        @(negedge clk);
        while (!busy && wait_n < 5) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, " busy rise"}, 64'(busy), 64'd1);
        if (!busy) return;
        len = 0;
        while (busy && len < 200) begin
            if (hex_bus !== last_disp) tear = 1'b1;
            len++;
            @(negedge clk);
        end
        check({tag, " busy fall"}, 64'(busy), 64'd0);
        if (check_len) check({tag, " busy len"}, 64'(len), 64'd28);
        check({tag, " no tearing"}, 64'(tear), 64'd0);
        check({tag, " scoreboard entry"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            check({tag, " display"}, 64'(hex_bus), 64'(exp));
            last_disp = exp;
        end
    endtask

    initial begin
        bit on;
        bit exp_buz;
        rst       = 1'b1;
        alarm     = 1'b0;
        hours     = '0;
        minutes   = '0;
        seconds   = '0;
        last_disp = ALL_BLANK;

        // Reset state.
        #1;
        check("reset hex", 64'(hex_bus), 64'(ALL_BLANK));
        check("reset buzzer", 64'(buzzer), 64'd0);
        check("reset busy", 64'(busy), 64'd0);

        // First conversion after release runs even with all-zero inputs.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0);
        wait_conv("zeros", 1'b1);
        check("zeros buzzer", 64'(buzzer), 64'd0);
        @(negedge clk);
        check("idle stays idle", 64'(busy), 64'd0);

        drive(23, 59, 58);
        wait_conv("23:59:58", 1'b1);

        // Input change mid-conversion: first commit shows the old value, a second conversion follows.
        drive(12, 34, 58);
        repeat (5) @(negedge clk);
        drive(12, 34, 59);
        wait_conv("12:34:58", 1'b0);
        wait_conv("12:34:59", 1'b1);
        check("hex0 after rerun", 64'(hex0), 64'h10);

        drive(7, 100, 5);
        wait_conv("minutes 100", 1'b1);
        check("dash hex3", 64'(hex3), 64'h3F);
        check("dash hex2", 64'(hex2), 64'h3F);
        check("leading zero hex5", 64'(hex5), 64'h40);

        // Alarm: blink half-period 4 cycles, tone half-period 2 cycles.
        alarm = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            on      = ((k / 4) % 2) == 0;
            exp_buz = (((k - 1) / 2) % 2 == 1) && (((k - 1) / 4) % 2 == 0);
            check($sformatf("blink hex k=%0d", k), 64'(hex_bus), 64'(on ? last_disp : ALL_BLANK));
            check($sformatf("buzzer k=%0d", k), 64'(buzzer), 64'(exp_buz));
        end
        alarm = 1'b0;
        @(negedge clk);
        check("alarm off hex", 64'(hex_bus), 64'(last_disp));
        check("alarm off buzzer", 64'(buzzer), 64'd0);

        // Reset between edges in the middle of a conversion.
        drive(9, 8, 7);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset hex", 64'(hex_bus), 64'(ALL_BLANK));
        check("async reset buzzer", 64'(buzzer), 64'd0);
        check("async reset busy", 64'(busy), 64'd0);
        sb_q.delete();
        last_disp = ALL_BLANK;
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(exp_disp(9, 8, 7));
        wait_conv("after reset", 1'b1);

        check("scoreboard drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
